// File: rtl/display_scan_decoder.sv
// Receiver for the multiplexed seven-segment scan: debounces each scanned digit, decodes it to
// hex and publishes a 16-bit value once all four digit positions have been seen.
module display_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_W          = 21
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [3:0]  bcd_enable,
  input  logic [6:0]  bcd_signal,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        pattern_err,
  output logic        stale,
  output logic [7:0]  frame_cnt
);

  localparam logic [7:0]       StableCnt  = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] TimeoutMax = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

  state_e           state_q, state_d;
  logic [3:0]       enable_q;
  logic [6:0]       signal_q;
  logic [3:0]       cand_en_q, cand_en_d;
  logic [6:0]       cand_seg_q, cand_seg_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       seen_q;
  logic [15:0]      shadow_q;
  logic             err_pend_q;
  logic [CNT_W-1:0] to_q;

  logic       legal, same, accept;
  logic [1:0] idx;
  logic [4:0] dec;

  // Active-high segments in, {non_hex, nibble} out.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F: return 5'h00;
      7'h06: return 5'h01;
      7'h5B: return 5'h02;
      7'h4F: return 5'h03;
      7'h66: return 5'h04;
      7'h6D: return 5'h05;
      7'h7D: return 5'h06;
      7'h07: return 5'h07;
      7'h7F: return 5'h08;
      7'h6F: return 5'h09;
      7'h77: return 5'h0A;
      7'h7C: return 5'h0B;
      7'h39: return 5'h0C;
      7'h5E: return 5'h0D;
      7'h79: return 5'h0E;
      7'h71: return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  always_comb begin
    legal = 1'b1;
    idx   = 2'd0;
    case (enable_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  assign same = (enable_q == cand_en_q) && (signal_q == cand_seg_q);
  assign dec  = seg_decode(~signal_q);

  always_comb begin
    state_d    = state_q;
    cand_en_d  = cand_en_q;
    cand_seg_d = cand_seg_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    if (!legal) begin
      state_d = StIdle;
      cnt_d   = 8'd0;
    end else if (state_q == StSettle && same) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == StableCnt) begin
        accept  = 1'b1;
        state_d = StHeld;
      end
    end else if (state_q == StHeld && same) begin
      state_d = StHeld;
    end else begin
      // Idle, a changed sample while settling, or leaving Held: restart on this very sample.
      cand_en_d  = enable_q;
      cand_seg_d = signal_q;
      cnt_d      = 8'd1;
      state_d    = StSettle;
      if (StableCnt == 8'd1) begin
        accept  = 1'b1;
        state_d = StHeld;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      enable_q    <= 4'hF;
      signal_q    <= 7'h7F;
      state_q     <= StIdle;
      cand_en_q   <= 4'hF;
      cand_seg_q  <= 7'h7F;
      cnt_q       <= 8'd0;
      seen_q      <= 4'd0;
      shadow_q    <= 16'd0;
      err_pend_q  <= 1'b0;
      to_q        <= '0;
      value       <= 16'd0;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      enable_q    <= bcd_enable;
      signal_q    <= bcd_signal;
      state_q     <= state_d;
      cand_en_q   <= cand_en_d;
      cand_seg_q  <= cand_seg_d;
      cnt_q       <= cnt_d;
      // Error flag waits one cycle so it lines up with the frame-completion pulse.
      err_pend_q  <= accept && dec[4];
      pattern_err <= err_pend_q;
      value_valid <= 1'b0;

      if (accept) begin
        shadow_q[4*idx +: 4] <= dec[4] ? 4'h0 : dec[3:0];
      end

      if (seen_q == 4'hF) begin
        value       <= shadow_q;
        value_valid <= 1'b1;
        frame_cnt   <= frame_cnt + 8'd1;
        seen_q      <= accept ? (4'b0001 << idx) : 4'd0;
      end else if (accept) begin
        seen_q <= seen_q | (4'b0001 << idx);
      end

      if (accept) begin
        to_q <= '0;
      end else if (to_q != TimeoutMax) begin
        to_q <= to_q + 1'b1;
      end
    end
  end

  assign stale = (to_q == TimeoutMax);

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: scans digit patterns with hand-computed results.
module tb_display_scan_decoder;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b0;
  logic [3:0]  bcd_enable = 4'hF;
  logic [6:0]  bcd_signal = 7'h7F;
  logic [15:0] value;
  logic        value_valid, pattern_err, stale;
  logic [7:0]  frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int vv_cnt  = 0;
  int err_cnt = 0;

  display_scan_decoder #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(100),
    .CNT_W         (7)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .bcd_enable (bcd_enable),
    .bcd_signal (bcd_signal),
    .value      (value),
    .value_valid(value_valid),
    .pattern_err(pattern_err),
    .stale      (stale),
    .frame_cnt  (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (reset) begin
      vv_cnt  <= vv_cnt + int'(value_valid);
      err_cnt <= err_cnt + int'(pattern_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shows one digit (active-high segment pattern) for 'hold' cycles, then blanks 2 cycles.
  task automatic show_digit(input int idx, input logic [6:0] seg, input int hold);
    logic [3:0] en;
    en = 4'hF;
    en[idx] = 1'b0;
    @(negedge sys_clk);
    bcd_enable = en;
    bcd_signal = ~seg;
    repeat (hold) @(negedge sys_clk);
    bcd_enable = 4'hF;
    bcd_signal = 7'h7F;
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    // Reset held with toggling inputs.
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      bcd_enable = 4'(i);
      bcd_signal = 7'(i * 13);
    end
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(value_valid), 32'h0);
    check("rst_err", 32'(pattern_err), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    check("rst_frame", 32'(frame_cnt), 32'h0);
    @(negedge sys_clk);
    bcd_enable = 4'hF;
    bcd_signal = 7'h7F;
    reset = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Frame 1: 16'h1A3F.
    show_digit(0, 7'h71, 8);
    show_digit(1, 7'h4F, 8);
    show_digit(2, 7'h77, 8);
    check("f1_partial_valid", 32'(vv_cnt), 32'd0);
    show_digit(3, 7'h06, 8);
    check("f1_value", 32'(value), 32'h1A3F);
    check("f1_valid_cnt", 32'(vv_cnt), 32'd1);
    check("f1_frame", 32'(frame_cnt), 32'd1);

    // Glitch on digit 0: '8' for 3 cycles then '9' for 3 cycles, never accepted.
    @(negedge sys_clk);
    bcd_enable = 4'b1110;
    bcd_signal = ~7'h7F;
    repeat (3) @(negedge sys_clk);
    bcd_signal = ~7'h6F;
    repeat (3) @(negedge sys_clk);
    bcd_enable = 4'hF;
    bcd_signal = 7'h7F;
    repeat (2) @(negedge sys_clk);
    // Digits 1..3 including a non-hex pattern on digit 2.
    show_digit(1, 7'h7D, 8);
    show_digit(2, 7'h00, 8);
    show_digit(3, 7'h79, 8);
    check("glitch_no_frame", 32'(vv_cnt), 32'd1);
    check("glitch_value_held", 32'(value), 32'h1A3F);
    check("bad_err_cnt", 32'(err_cnt), 32'd1);
    show_digit(0, 7'h7C, 8);
    check("f2_value", 32'(value), 32'hE06B);
    check("f2_frame", 32'(frame_cnt), 32'd2);
    check("f2_valid_cnt", 32'(vv_cnt), 32'd2);

    // Illegal two-hot enable is blanking; a later scan completes normally.
    @(negedge sys_clk);
    bcd_enable = 4'b1100;
    bcd_signal = ~7'h3F;
    repeat (20) @(negedge sys_clk);
    bcd_enable = 4'hF;
    bcd_signal = 7'h7F;
    repeat (2) @(negedge sys_clk);
    show_digit(1, 7'h5B, 8);
    show_digit(2, 7'h06, 8);
    show_digit(3, 7'h3F, 8);
    check("illegal_no_frame", 32'(vv_cnt), 32'd2);
    show_digit(0, 7'h4F, 8);
    check("f3_value", 32'(value), 32'h0123);
    check("f3_frame", 32'(frame_cnt), 32'd3);
    check("fresh_not_stale", 32'(stale), 32'd0);

    // Timeout, then recovery on a single accepted digit.
    repeat (101) @(negedge sys_clk);
    check("stale_set", 32'(stale), 32'd1);
    check("stale_value_held", 32'(value), 32'h0123);
    bcd_enable = 4'b1110;
    bcd_signal = ~7'h6D;
    repeat (4) @(negedge sys_clk);
    check("stale_before_accept", 32'(stale), 32'd1);
    @(negedge sys_clk);
    check("stale_cleared", 32'(stale), 32'd0);
    repeat (4) @(negedge sys_clk);
    bcd_enable = 4'hF;
    bcd_signal = 7'h7F;
    repeat (3) @(negedge sys_clk);
    check("stale_frame_same", 32'(frame_cnt), 32'd3);
    check("stale_err_cnt", 32'(err_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
